// File: rtl/decoder_nxm_stream.sv
// rtl/decoder_nxm_stream.sv - registered SEL_W-to-2**SEL_W one-hot decoder with valid/ready and walking scan mode
// Optional even-parity check on direct selects: define DEC_PARITY_EN.
module decoder_nxm_stream #(
  parameter int SEL_W    = 3,
  parameter int SCAN_MAX = (1 << SEL_W) - 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     mode,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_W-1:0]         in,
`ifdef DEC_PARITY_EN
  input  logic                     in_par,
  output logic                     err,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [(1 << SEL_W)-1:0]  out,
  output logic [SEL_W-1:0]         idx,
  output logic                     scan_wrap
);

  localparam int OUT_W = 1 << SEL_W;
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;
  localparam logic [SEL_W-1:0] SCAN_LAST = SEL_W'(SCAN_MAX);
  localparam logic [OUT_W-1:0] ONE = OUT_W'(1);

  logic [0:0]       state_q, state_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [SEL_W-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             mode_q;

  logic             free;
  logic             direct_load;
  logic             scan_load;
  logic             scan_start;
  logic [SEL_W-1:0] scan_idx;
  logic             sel_bad;

`ifdef DEC_PARITY_EN
  logic err_q, err_d;
  assign sel_bad = ^{in, in_par};
  assign err     = err_q;
`else
  assign sel_bad = 1'b0;
`endif

  assign out_valid = (state_q == ST_FULL);
  assign out       = out_q;
  assign idx       = idx_q;
  assign scan_wrap = wrap_q;

  // A slot is free when empty or when the held beat leaves this cycle.
  assign free        = !out_valid || out_ready;
  assign in_ready    = rst_n && en && !mode && free;
  assign direct_load = in_valid && in_ready;
  assign scan_load   = en && mode && free;

  // Entering scan restarts the walk at index 0 regardless of the stored count.
  assign scan_start = mode && !mode_q;
  assign scan_idx   = scan_start ? '0 : cnt_q;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    idx_d   = idx_q;
    cnt_d   = scan_idx;
    wrap_d  = 1'b0;
`ifdef DEC_PARITY_EN
    err_d   = err_q;
`endif
    if (direct_load) begin
      state_d = ST_FULL;
      idx_d   = in;
      out_d   = sel_bad ? '0 : (ONE << in);
`ifdef DEC_PARITY_EN
      if (sel_bad) err_d = 1'b1;
`endif
    end else if (scan_load) begin
      state_d = ST_FULL;
      idx_d   = scan_idx;
      out_d   = ONE << scan_idx;
      wrap_d  = (scan_idx == SCAN_LAST);
      cnt_d   = (scan_idx == SCAN_LAST) ? '0 : scan_idx + SEL_W'(1);
    end else if (out_valid && out_ready) begin
      state_d = ST_EMPTY;
      out_d   = '0;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      out_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
      mode_q  <= 1'b0;
`ifdef DEC_PARITY_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
      mode_q  <= mode;
`ifdef DEC_PARITY_EN
      err_q   <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_decoder_nxm_stream.sv
// tb/tb_decoder_nxm_stream.sv - self-checking bench for decoder_nxm_stream
// Directed vector table, hand sequences, then randomized traffic against a transaction-level model.
module tb_decoder_nxm_stream;

  localparam int SEL_W    = 3;
  localparam int SCAN_MAX = 3;

  logic       clk = 1'b0;
  logic       rst_n, en, mode, in_valid, in_ready, out_valid, out_ready, scan_wrap;
  logic [2:0] sel, idx;
  logic [7:0] out;
`ifdef DEC_PARITY_EN
  logic       in_par, err;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decoder_nxm_stream #(.SEL_W(SEL_W), .SCAN_MAX(SCAN_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in(sel),
`ifdef DEC_PARITY_EN
    .in_par(in_par), .err(err),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .idx(idx), .scan_wrap(scan_wrap)
  );

  typedef struct {
    logic       rst_n, en, mode, iv;
    logic [2:0] sel;
    logic       ordy;
    logic       exp_ready;
    logic [7:0] exp_out;
    logic       exp_valid;
    logic [2:0] exp_idx;
    logic       exp_wrap;
  } row_t;

  // Transaction-level reference: a held beat (valid + index) and a scan position.
  bit m_valid;
  int m_idx;
  int m_cnt;
  bit m_prev_mode;
  bit m_wrap;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit fr;
    if (!rst_n) begin
      m_valid = 0; m_idx = 0; m_cnt = 0; m_prev_mode = 0; m_wrap = 0;
    end else begin
      fr = !m_valid || out_ready;
      m_wrap = 0;
      if (mode && !m_prev_mode) m_cnt = 0;
      if (!mode && en && fr && in_valid) begin
        m_valid = 1; m_idx = int'(sel);
      end else if (mode && en && fr) begin
        m_valid = 1; m_idx = m_cnt;
        m_wrap = (m_cnt == SCAN_MAX);
        m_cnt = (m_cnt + 1) % (SCAN_MAX + 1);
      end else if (m_valid && out_ready) begin
        m_valid = 0; m_idx = 0;
      end
      m_prev_mode = mode;
    end
  endtask

  task automatic drive(input row_t r);
    rst_n = r.rst_n; en = r.en; mode = r.mode; in_valid = r.iv; sel = r.sel; out_ready = r.ordy;
`ifdef DEC_PARITY_EN
    in_par = ^r.sel;
`endif
  endtask

  task automatic apply_row(input string name, input row_t r);
    drive(r);
    @(negedge clk);
    chk({name, ".in_ready"}, 32'(in_ready), 32'(r.exp_ready));
    @(posedge clk);
    model_step();
    #1;
    chk({name, ".out"}, 32'(out), 32'(r.exp_out));
    chk({name, ".out_valid"}, 32'(out_valid), 32'(r.exp_valid));
    chk({name, ".idx"}, 32'(idx), 32'(r.exp_idx));
    chk({name, ".scan_wrap"}, 32'(scan_wrap), 32'(r.exp_wrap));
  endtask

  function automatic row_t mk(input logic rn, e, md, iv, input logic [2:0] s, input logic ordy,
                              input logic xr, input logic [7:0] xo, input logic xv,
                              input logic [2:0] xi, input logic xw);
    row_t r;
    r.rst_n = rn; r.en = e; r.mode = md; r.iv = iv; r.sel = s; r.ordy = ordy;
    r.exp_ready = xr; r.exp_out = xo; r.exp_valid = xv; r.exp_idx = xi; r.exp_wrap = xw;
    return r;
  endfunction

  row_t tbl[$];

  initial begin
    logic [7:0] onehot;
    drive(mk(0, 1, 0, 1, 3'd3, 1, 0, 0, 0, 0, 0));

    // Reset, direct sweep, stall, drain, enable-off.
    tbl.push_back(mk(0, 1, 0, 1, 3'd3, 1, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 3'd3, 1, 0, 8'h00, 0, 0, 0));
    for (int i = 0; i < 8; i++) begin
      onehot = 8'h01 << i;
      tbl.push_back(mk(1, 1, 0, 1, 3'(i), 1, 1, onehot, 1, 3'(i), 0));
    end
    tbl.push_back(mk(1, 1, 0, 1, 3'd5, 1, 1, 8'h20, 1, 3'd5, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1, 1, 0, 1, 3'd6, 0, 0, 8'h20, 1, 3'd5, 0));
    tbl.push_back(mk(1, 1, 0, 1, 3'd6, 1, 1, 8'h40, 1, 3'd6, 0));
    tbl.push_back(mk(1, 1, 0, 0, 3'd1, 1, 1, 8'h00, 0, 3'd0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 3'd2, 1, 0, 8'h00, 0, 3'd0, 0));
    foreach (tbl[i]) apply_row($sformatf("vec%0d", i), tbl[i]);

    // Scan walk with wrap, then stall, en=0 drain and counter freeze.
    apply_row("scan0", mk(1, 1, 1, 0, 0, 1, 0, 8'h01, 1, 3'd0, 0));
    apply_row("scan1", mk(1, 1, 1, 0, 0, 1, 0, 8'h02, 1, 3'd1, 0));
    apply_row("scan2", mk(1, 1, 1, 0, 0, 1, 0, 8'h04, 1, 3'd2, 0));
    apply_row("scan3", mk(1, 1, 1, 0, 0, 1, 0, 8'h08, 1, 3'd3, 1));
    apply_row("scan4", mk(1, 1, 1, 0, 0, 1, 0, 8'h01, 1, 3'd0, 0));
    apply_row("scan_stall", mk(1, 1, 1, 0, 0, 0, 0, 8'h01, 1, 3'd0, 0));
    apply_row("scan_en0", mk(1, 0, 1, 0, 0, 1, 0, 8'h00, 0, 3'd0, 0));
    apply_row("scan_en0b", mk(1, 0, 1, 0, 0, 1, 0, 8'h00, 0, 3'd0, 0));
    apply_row("scan_resume", mk(1, 1, 1, 0, 0, 1, 0, 8'h02, 1, 3'd1, 0));

    // Re-entering scan restarts at 0; mid-stream reset drops the held beat.
    apply_row("dir4", mk(1, 1, 0, 1, 3'd4, 1, 1, 8'h10, 1, 3'd4, 0));
    apply_row("rst_dir", mk(0, 1, 0, 1, 3'd4, 1, 0, 8'h00, 0, 3'd0, 0));
    apply_row("rescan0", mk(1, 1, 1, 0, 0, 1, 0, 8'h01, 1, 3'd0, 0));
    apply_row("rescan1", mk(1, 1, 1, 0, 0, 1, 0, 8'h02, 1, 3'd1, 0));
    apply_row("rst_scan", mk(0, 1, 1, 0, 0, 1, 0, 8'h00, 0, 3'd0, 0));
    apply_row("post_rst", mk(1, 1, 1, 0, 0, 1, 0, 8'h01, 1, 3'd0, 0));

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 11) == 0) mode = ~mode;
      in_valid = $urandom_range(0, 1);
      sel = 3'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
`ifdef DEC_PARITY_EN
      in_par = ^sel;
`endif
      @(negedge clk);
      chk("rnd.in_ready", 32'(in_ready), 32'(rst_n && en && !mode && (!m_valid || out_ready)));
      @(posedge clk);
      model_step();
      #1;
      chk("rnd.out_valid", 32'(out_valid), 32'(m_valid));
      chk("rnd.out", 32'(out), m_valid ? (32'd1 << m_idx) : 32'd0);
      chk("rnd.idx", 32'(idx), 32'(m_idx));
      chk("rnd.scan_wrap", 32'(scan_wrap), 32'(m_wrap));
    end

`ifdef DEC_PARITY_EN
    apply_row("par_rst", mk(0, 1, 0, 0, 0, 1, 0, 8'h00, 0, 3'd0, 0));
    @(negedge clk);
    chk("par.err_reset", 32'(err), 32'd0);
    rst_n = 1; en = 1; mode = 0; in_valid = 1; sel = 3'd3; in_par = 1; out_ready = 1;
    @(posedge clk); #1;
    chk("par.bad_out", 32'(out), 32'h00);
    chk("par.bad_valid", 32'(out_valid), 32'd1);
    chk("par.bad_idx", 32'(idx), 32'd3);
    chk("par.err_set", 32'(err), 32'd1);
    in_par = 0;
    @(posedge clk); #1;
    chk("par.good_out", 32'(out), 32'h08);
    chk("par.err_sticky", 32'(err), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
